// File: rtl/prog_pbox.sv
// Programmable bit permutation: out[i] = in[table[i]], one registered output stage.
// The table resets to identity and can only be rewritten while no result is pending.
module prog_pbox #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             bypass,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             cfg_we,
    output logic             cfg_ready,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [IDX_W-1:0] cfg_idx,
    output logic             cfg_err
);

    localparam logic [IDX_W:0] LIMIT = (IDX_W + 1)'(WIDTH);

    logic [IDX_W-1:0] tbl_q [WIDTH];
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             cfg_err_q;
    logic [WIDTH-1:0] perm;
    logic             in_fire;
    logic             out_fire;
    logic             cfg_fire;
    logic             cfg_legal;

    // A table write takes priority over an input in the same cycle.
    assign cfg_ready = !rst && !out_valid_q;
    assign in_ready  = !rst && (!out_valid_q || out_ready) && !(cfg_we && cfg_ready);

    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;
    assign cfg_fire  = cfg_we && cfg_ready;
    assign cfg_legal = ({1'b0, cfg_addr} < LIMIT) && ({1'b0, cfg_idx} < LIMIT);

    always_comb begin
        perm = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            perm[i] = in_data[tbl_q[i]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            cfg_err_q   <= 1'b0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                tbl_q[i] <= IDX_W'(i);
            end
        end else begin
            if (in_fire) begin
                out_valid_q <= 1'b1;
                out_data_q  <= bypass ? in_data : perm;
            end else if (out_fire) begin
                out_valid_q <= 1'b0;
            end
            // Illegal writes still complete the handshake but leave the table alone.
            if (cfg_fire) begin
                if (cfg_legal) begin
                    tbl_q[cfg_addr] <= cfg_idx;
                end else begin
                    cfg_err_q <= 1'b1;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign cfg_err   = cfg_err_q;

endmodule
